// File: rtl/feistel_cipher_iter.sv
// -----------------------------------------------------------------------------
// feistel_cipher_iter
//
// Iterative Feistel block cipher engine. A single ARX round function is reused
// once per clock, so the datapath size does not depend on the round count.
// Round keys are written into a small key file by the key generator. Blocks
// stream in and out over valid/ready handshakes.
//
// Handshake rule (both s_ and m_ sides): a transfer happens on a rising clk
// edge where valid and ready are both high. A valid that meets ready low
// transfers nothing. Data is sampled only on the transfer edge.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   key_we       round-key write strobe
//   key_idx      round-key index
//   key_wdata    round-key value (HALF bits)
//   key_err      one-cycle pulse when a key write is rejected
//   keys_loaded  high once every key index has been written since reset
//   s_valid      input block valid
//   s_ready      engine can accept a block (IDLE and keys loaded)
//   s_mode       0 = encrypt, 1 = decrypt, sampled at accept
//   s_data       input block, L = upper half, R = lower half
//   m_valid      output block valid (DONE state)
//   m_ready      downstream accepts the output
//   m_data       result {R_final, L_final}, held until the handshake
//   busy         high in RUN or DONE
// -----------------------------------------------------------------------------
module feistel_cipher_iter #(
    parameter int DATA_WIDTH = 256,
    parameter int ROUNDS     = 5,
    parameter int ROT        = 7,
    parameter int IDXW       = (ROUNDS > 1 ? $clog2(ROUNDS) : 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_we,
    input  logic [IDXW-1:0]         key_idx,
    input  logic [DATA_WIDTH/2-1:0] key_wdata,
    output logic                    key_err,
    output logic                    keys_loaded,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_mode,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    busy
);

    localparam int HALF = DATA_WIDTH / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [HALF-1:0]       l_q;
    logic [HALF-1:0]       r_q;
    logic                  mode_q;
    logic [IDXW-1:0]       cnt;
    logic [HALF-1:0]       keys [ROUNDS];
    logic [ROUNDS-1:0]     mask;
    logic [ROUNDS-1:0]     mask_next;
    logic [DATA_WIDTH-1:0] m_data_q;

    logic                  key_ok;
    logic                  accept;
    logic [HALF-1:0]       round_key;
    logic [HALF-1:0]       f_sum;
    logic [HALF-1:0]       f_out;
    logic [HALF-1:0]       r_new;
    int                    key_sel;

    // Key writes land only while idle and only for existing indices.
    assign key_ok  = key_we && (state == S_IDLE) && (int'(key_idx) < ROUNDS);
    assign s_ready = (state == S_IDLE) && keys_loaded;
    assign accept  = s_valid && s_ready;
    assign m_valid = (state == S_DONE);
    assign busy    = (state != S_IDLE);
    assign m_data  = m_data_q;

    always_comb begin
        mask_next = mask;
        for (int i = 0; i < ROUNDS; i++) begin
            if (key_ok && int'(key_idx) == i) begin
                mask_next[i] = 1'b1;
            end
        end
    end

    // Decrypt walks the key schedule backwards.
    always_comb begin
        key_sel   = mode_q ? (ROUNDS - 1 - int'(cnt)) : int'(cnt);
        round_key = '0;
        for (int i = 0; i < ROUNDS; i++) begin
            if (key_sel == i) begin
                round_key = keys[i];
            end
        end
    end

    // F(x,k) = ROTL(x + k) ^ k. A zero rotate shifts the right term out
    // entirely, leaving the sum unchanged.
    always_comb begin
        f_sum = r_q + round_key;
        f_out = ((f_sum << ROT) | (f_sum >> (HALF - ROT))) ^ round_key;
        r_new = l_q ^ f_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            l_q         <= '0;
            r_q         <= '0;
            mode_q      <= 1'b0;
            cnt         <= '0;
            mask        <= '0;
            keys_loaded <= 1'b0;
            key_err     <= 1'b0;
            m_data_q    <= '0;
            for (int i = 0; i < ROUNDS; i++) begin
                keys[i] <= '0;
            end
        end else begin
            key_err     <= key_we && !key_ok;
            mask        <= mask_next;
            // Reflects this edge's write, so it rises right after the last
            // missing key is stored.
            keys_loaded <= &mask_next;
            for (int i = 0; i < ROUNDS; i++) begin
                if (key_ok && int'(key_idx) == i) begin
                    keys[i] <= key_wdata;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        l_q    <= s_data[DATA_WIDTH-1:HALF];
                        r_q    <= s_data[HALF-1:0];
                        mode_q <= s_mode;
                        cnt    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    l_q <= r_q;
                    r_q <= r_new;
                    if (int'(cnt) == ROUNDS - 1) begin
                        // Final swap: output is {R', L'}.
                        m_data_q <= {r_new, r_q};
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (m_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feistel_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_feistel_cipher_iter
//
// Directed bench for feistel_cipher_iter with DATA_WIDTH=16, ROUNDS=2, ROT=1
// and keys K0=0x01, K1=0x02. Expected values were worked by hand:
//   enc 0x1234 -> 0xC079   dec 0xC079 -> 0x1234
//   enc 0xAAAA -> 0x55FC   enc 0x1234 with K1=0x03 -> 0xCF79
// IDXW is widened to 2 so an out-of-range index (2) can be driven at all.
// -----------------------------------------------------------------------------
module tb_feistel_cipher_iter;

    localparam int DW     = 16;
    localparam int ROUNDS = 2;
    localparam int IDXW   = 2;

    logic          clk;
    logic          reset;
    logic          key_we;
    logic [IDXW-1:0] key_idx;
    logic [DW/2-1:0] key_wdata;
    logic          key_err;
    logic          keys_loaded;
    logic          s_valid;
    logic          s_ready;
    logic          s_mode;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    feistel_cipher_iter #(
        .DATA_WIDTH(DW),
        .ROUNDS    (ROUNDS),
        .ROT       (1),
        .IDXW      (IDXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_we     (key_we),
        .key_idx    (key_idx),
        .key_wdata  (key_wdata),
        .key_err    (key_err),
        .keys_loaded(keys_loaded),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_mode     (s_mode),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic write_key(input logic [IDXW-1:0] idx, input logic [DW/2-1:0] val);
        key_we    = 1'b1;
        key_idx   = idx;
        key_wdata = val;
        tick();
        key_we    = 1'b0;
    endtask

    // Full block with m_ready high: accept, latency, result, release.
    task automatic do_block(input string tag, input logic [DW-1:0] data,
                            input logic mode, input logic [DW-1:0] exp);
        int n;
        logic [DW-1:0] want;
        s_valid = 1'b1;
        s_data  = data;
        s_mode  = mode;
        exp_q.push_back(exp);
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_valid && n < 20);
        check({tag, "_latency"}, 32'(n), 32'(ROUNDS));
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_data"}, 32'(m_data), 32'(want));
        tick();
        check({tag, "_mvalid_low"}, 32'(m_valid), 32'd0);
        check({tag, "_sready_after"}, 32'(s_ready), 32'd1);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        key_we    = 1'b0;
        key_idx   = '0;
        key_wdata = '0;
        s_valid   = 1'b0;
        s_mode    = 1'b0;
        s_data    = '0;
        m_ready   = 1'b1;
        tick();
        tick();
        check("rst_mvalid", 32'(m_valid), 32'd0);
        check("rst_sready", 32'(s_ready), 32'd0);
        check("rst_loaded", 32'(keys_loaded), 32'd0);
        check("rst_keyerr", 32'(key_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mdata", 32'(m_data), 32'd0);
        reset = 1'b0;
        tick();

        // key load
        write_key(2'd0, 8'h01);
        check("load1_loaded", 32'(keys_loaded), 32'd0);
        check("load1_sready", 32'(s_ready), 32'd0);
        write_key(2'd1, 8'h02);
        check("load2_loaded", 32'(keys_loaded), 32'd1);
        check("load2_sready", 32'(s_ready), 32'd1);
        check("load2_keyerr", 32'(key_err), 32'd0);

        // KATs
        do_block("enc", 16'h1234, 1'b0, 16'hC079);
        do_block("dec", 16'hC079, 1'b1, 16'h1234);

        // backpressure
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        s_mode  = 1'b0;
        tick();
        s_data  = 16'hAAAA;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_valid && n < 20);
        check("bp_latency", 32'(n), 32'(ROUNDS));
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", 32'(m_data), 32'hC079);
            check("bp_hold_sready", 32'(s_ready), 32'd0);
            check("bp_hold_mvalid", 32'(m_valid), 32'd1);
            tick();
        end
        m_ready = 1'b1;
        check("bp_release_data", 32'(m_data), 32'hC079);
        tick();
        check("bp_mvalid_low", 32'(m_valid), 32'd0);
        check("bp_sready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("bp_busy", 32'(busy), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_valid && n < 20);
        check("bp_aaaa_latency", 32'(n), 32'(ROUNDS));
        check("bp_aaaa_data", 32'(m_data), 32'h55FC);
        tick();
        do_block("dec_aaaa", 16'h55FC, 1'b1, 16'hAAAA);

        // key write during RUN is rejected
        s_valid = 1'b1;
        s_data  = 16'h1234;
        s_mode  = 1'b0;
        tick();
        s_valid   = 1'b0;
        key_we    = 1'b1;
        key_idx   = 2'd1;
        key_wdata = 8'hFF;
        tick();
        key_we = 1'b0;
        check("run_wr_keyerr", 32'(key_err), 32'd1);
        tick();
        check("run_wr_keyerr_pulse", 32'(key_err), 32'd0);
        check("run_wr_mvalid", 32'(m_valid), 32'd1);
        check("run_wr_data", 32'(m_data), 32'hC079);
        tick();

        // out-of-range index in IDLE is rejected
        write_key(2'd2, 8'h55);
        check("idx2_keyerr", 32'(key_err), 32'd1);
        check("idx2_loaded", 32'(keys_loaded), 32'd1);
        tick();
        check("idx2_keyerr_pulse", 32'(key_err), 32'd0);
        do_block("idx2_enc", 16'h1234, 1'b0, 16'hC079);

        // key write in the accept cycle is used by that block
        key_we    = 1'b1;
        key_idx   = 2'd1;
        key_wdata = 8'h03;
        s_valid   = 1'b1;
        s_data    = 16'h1234;
        s_mode    = 1'b0;
        tick();
        key_we  = 1'b0;
        s_valid = 1'b0;
        check("same_keyerr", 32'(key_err), 32'd0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_valid && n < 20);
        check("same_data", 32'(m_data), 32'hCF79);
        tick();
        write_key(2'd1, 8'h02);

        // reset mid-RUN
        s_valid = 1'b1;
        s_data  = 16'h1234;
        s_mode  = 1'b0;
        tick();
        s_valid = 1'b0;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        check("rrun_mvalid", 32'(m_valid), 32'd0);
        check("rrun_sready", 32'(s_ready), 32'd0);
        check("rrun_loaded", 32'(keys_loaded), 32'd0);
        check("rrun_busy", 32'(busy), 32'd0);
        tick();
        check("rrun_mvalid2", 32'(m_valid), 32'd0);
        write_key(2'd0, 8'h01);
        write_key(2'd1, 8'h02);
        check("rrun_reloaded", 32'(keys_loaded), 32'd1);
        do_block("rrun_enc", 16'h1234, 1'b0, 16'hC079);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
